csr_file_m: RTL and testbench

- Parametrised machine-mode CSR file for the core.
- Width-generic (RV32/RV64). Supports CSRRW/CSRRS/CSRRC write modes, trap entry/return stacking of mstatus.MIE, a free-running 64-bit mcycle counter, a scratch register and read-only ID registers.
- Sits beside the register file.
  - Inputs: decode supplies the address and op; execute supplies the operand; the trap/mret controls come from the commit stage.
  - Outputs: trap vector and return PC go to the PC-select logic.

---
 rtl/csr_file_m.sv | 214 +++++++++++++++++++++
 tb/tb_csr_file_m.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_file_m.sv
// csr_file_m: machine-mode CSR file. Reads are combinational with zero latency, and writes, traps and mret take effect at the next edge; there is no backpressure.
// Optional minstret/minstreth counters are built when YSYX_23060251_CSR_MINSTRET_EN is defined.
module csr_file_m #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] MTVEC_RESET = '0,
    parameter logic [XLEN-1:0] MARCHID     = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [1:0]      csr_op_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [XLEN-1:0] trap_cause_i,
    input  logic            mret_i,
    input  logic            retire_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            illegal_o,
    output logic [XLEN-1:0] mtvec_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_o
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_RW   = 2'b01;
    localparam logic [1:0] OP_RS   = 2'b10;
    localparam logic [1:0] OP_RC   = 2'b11;

    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    localparam bit              HAS_HI     = (XLEN == 32);

    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mscratch;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [63:0]     r_mcycle;

    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_rd;
    logic [XLEN-1:0] w_wval;
    logic            w_impl;
    logic            w_ro;
    logic            w_illegal;
    logic            w_wen;
    logic            w_cyc_wr_lo;
    logic            w_cyc_wr_hi;
    logic [63:0]     w_mcycle_nxt;

    // A write to either half replaces that half and holds the counter for that cycle.
    function automatic logic [63:0] f_cnt_next(
        input logic [63:0]     cur,
        input logic            inc,
        input logic            wr_lo,
        input logic            wr_hi,
        input logic [XLEN-1:0] val
    );
        logic [63:0] nxt;
        nxt = inc ? cur + 64'd1 : cur;
        if (wr_lo) begin
            nxt = (XLEN == 64) ? 64'(val) : {cur[63:32], val[31:0]};
        end else if (wr_hi) begin
            nxt = {val[31:0], cur[31:0]};
        end
        return nxt;
    endfunction

`ifdef YSYX_23060251_CSR_MINSTRET_EN
    logic [63:0] r_minstret;
    logic        w_ret_wr_lo;
    logic        w_ret_wr_hi;
    logic [63:0] w_minstret_nxt;
`else
    logic        w_unused_retire;
    assign w_unused_retire = retire_i;
`endif

    always_comb begin
        w_mstatus        = '0;
        w_mstatus[12:11] = 2'b11;
        w_mstatus[7]     = r_mpie;
        w_mstatus[3]     = r_mie;
    end

    always_comb begin
        w_rd   = '0;
        w_impl = 1'b1;
        w_ro   = 1'b0;
        case (csr_addr_i)
            ADDR_MSTATUS:  w_rd = w_mstatus;
            ADDR_MTVEC:    w_rd = r_mtvec;
            ADDR_MSCRATCH: w_rd = r_mscratch;
            ADDR_MEPC:     w_rd = r_mepc;
            ADDR_MCAUSE:   w_rd = r_mcause;
            ADDR_MCYCLE:   w_rd = r_mcycle[XLEN-1:0];
            ADDR_MCYCLEH: begin
                if (HAS_HI) begin
                    w_rd = XLEN'(r_mcycle[63:32]);
                end else begin
                    w_impl = 1'b0;
                end
            end
`ifdef YSYX_23060251_CSR_MINSTRET_EN
            ADDR_MINSTRET: w_rd = r_minstret[XLEN-1:0];
            ADDR_MINSTRETH: begin
                if (HAS_HI) begin
                    w_rd = XLEN'(r_minstret[63:32]);
                end else begin
                    w_impl = 1'b0;
                end
            end
`endif
            ADDR_MVENDORID: w_ro = 1'b1;
            ADDR_MARCHID: begin
                w_rd = MARCHID;
                w_ro = 1'b1;
            end
            default: w_impl = 1'b0;
        endcase
    end

    assign w_illegal = (csr_op_i != OP_NONE) && (!w_impl || w_ro);
    assign illegal_o = w_illegal;
    assign rdata_o   = w_illegal ? '0 : w_rd;

    always_comb begin
        w_wval = w_rd;
        case (csr_op_i)
            OP_RW:   w_wval = csr_wdata_i;
            OP_RS:   w_wval = w_rd | csr_wdata_i;
            OP_RC:   w_wval = w_rd & ~csr_wdata_i;
            default: w_wval = w_rd;
        endcase
    end

    // Trap and mret own the edge; a software write in the same cycle is dropped.
    assign w_wen = (csr_op_i != OP_NONE) && !w_illegal && !trap_i && !mret_i;

    assign w_cyc_wr_lo  = w_wen && (csr_addr_i == ADDR_MCYCLE);
    assign w_cyc_wr_hi  = w_wen && (csr_addr_i == ADDR_MCYCLEH) && HAS_HI;
    assign w_mcycle_nxt = f_cnt_next(r_mcycle, 1'b1, w_cyc_wr_lo, w_cyc_wr_hi, w_wval);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mcycle <= '0;
        end else begin
            r_mcycle <= w_mcycle_nxt;
        end
    end

`ifdef YSYX_23060251_CSR_MINSTRET_EN
    assign w_ret_wr_lo    = w_wen && (csr_addr_i == ADDR_MINSTRET);
    assign w_ret_wr_hi    = w_wen && (csr_addr_i == ADDR_MINSTRETH) && HAS_HI;
    assign w_minstret_nxt = f_cnt_next(r_minstret, retire_i, w_ret_wr_lo, w_ret_wr_hi, w_wval);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_minstret <= '0;
        end else begin
            r_minstret <= w_minstret_nxt;
        end
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RESET & ALIGN_MASK;
            r_mscratch <= '0;
            r_mepc     <= '0;
            r_mcause   <= '0;
        end else if (trap_i) begin
            r_mepc   <= trap_pc_i & ALIGN_MASK;
            r_mcause <= trap_cause_i;
            r_mpie   <= r_mie;
            r_mie    <= 1'b0;
        end else if (mret_i) begin
            r_mie  <= r_mpie;
            r_mpie <= 1'b1;
        end else if (w_wen) begin
            case (csr_addr_i)
                ADDR_MSTATUS: begin
                    r_mie  <= w_wval[3];
                    r_mpie <= w_wval[7];
                end
                ADDR_MTVEC:    r_mtvec    <= w_wval & ALIGN_MASK;
                ADDR_MSCRATCH: r_mscratch <= w_wval;
                ADDR_MEPC:     r_mepc     <= w_wval & ALIGN_MASK;
                ADDR_MCAUSE:   r_mcause   <= w_wval;
                default: ;
            endcase
        end
    end

    assign mtvec_o = r_mtvec;
    assign mepc_o  = r_mepc;
    assign mie_o   = r_mie;

endmodule

// File: tb/tb_csr_file_m.sv
// Bench for csr_file_m: an RV32 instance is tracked cycle-by-cycle against a CSR model.
// An RV64 instance shares the stimulus and is pinned with literal expectations.
module tb_csr_file_m;

    localparam logic [31:0] MTV  = 32'h0000_1003;
    localparam logic [31:0] MAID = 32'h0000_002A;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] addr;
    logic [1:0]  op;
    logic [31:0] wd, pc, cause;
    logic        trap, mret, retire;
    logic        done;

    logic [31:0] rd32, mtvec32, mepc32;
    logic        ill32, mie32;
    logic [63:0] rd64, mtvec64, mepc64;
    logic        ill64, mie64;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    csr_file_m #(.XLEN(32), .MTVEC_RESET(MTV), .MARCHID(MAID)) u_dut32 (
        .clk_i(clk), .rst_i(rst), .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i(wd),
        .trap_i(trap), .trap_pc_i(pc), .trap_cause_i(cause), .mret_i(mret), .retire_i(retire),
        .rdata_o(rd32), .illegal_o(ill32), .mtvec_o(mtvec32), .mepc_o(mepc32), .mie_o(mie32)
    );

    csr_file_m #(.XLEN(64), .MTVEC_RESET({32'h0, MTV}), .MARCHID({32'h0, MAID})) u_dut64 (
        .clk_i(clk), .rst_i(rst), .csr_addr_i(addr), .csr_op_i(op), .csr_wdata_i({32'h0, wd}),
        .trap_i(trap), .trap_pc_i({32'h0, pc}), .trap_cause_i({32'h0, cause}), .mret_i(mret),
        .retire_i(retire),
        .rdata_o(rd64), .illegal_o(ill64), .mtvec_o(mtvec64), .mepc_o(mepc64), .mie_o(mie64)
    );

    // Architectural state of the RV32 instance.
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_mscratch;
    logic [63:0] m_cyc;
    logic        m_wr;

    function automatic logic m_impl(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hF11, 12'hF12};
    endfunction

    function automatic logic m_ill(input logic [11:0] a, input logic [1:0] o);
        return (o != 2'b00) && (!m_impl(a) || a == 12'hF11 || a == 12'hF12);
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00: return m_cyc[31:0];
            12'hB80: return m_cyc[63:32];
            12'hF12: return MAID;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_new(input logic [1:0] o, input logic [31:0] old,
                                          input logic [31:0] d);
        case (o)
            2'b01:   return d;
            2'b10:   return old | d;
            2'b11:   return old & ~d;
            default: return old;
        endcase
    endfunction

    assign m_wr = !trap && !mret && (op != 2'b00) && !m_ill(addr, op);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mie      <= 1'b0;
            m_mpie     <= 1'b0;
            m_mtvec    <= MTV & 32'hFFFF_FFFC;
            m_mepc     <= 32'h0;
            m_mcause   <= 32'h0;
            m_mscratch <= 32'h0;
            m_cyc      <= 64'h0;
        end else begin
            if (trap) begin
                m_mepc   <= pc & 32'hFFFF_FFFC;
                m_mcause <= cause;
                m_mpie   <= m_mie;
                m_mie    <= 1'b0;
            end else if (mret) begin
                m_mie  <= m_mpie;
                m_mpie <= 1'b1;
            end else if (m_wr) begin
                case (addr)
                    12'h300: begin
                        m_mie  <= |(m_new(op, m_read(addr), wd) & 32'h8);
                        m_mpie <= |(m_new(op, m_read(addr), wd) & 32'h80);
                    end
                    12'h305: m_mtvec    <= m_new(op, m_read(addr), wd) & 32'hFFFF_FFFC;
                    12'h340: m_mscratch <= m_new(op, m_read(addr), wd);
                    12'h341: m_mepc     <= m_new(op, m_read(addr), wd) & 32'hFFFF_FFFC;
                    12'h342: m_mcause   <= m_new(op, m_read(addr), wd);
                    default: ;
                endcase
            end
            if (m_wr && addr == 12'hB00)      m_cyc <= {m_cyc[63:32], m_new(op, m_read(addr), wd)};
            else if (m_wr && addr == 12'hB80) m_cyc <= {m_new(op, m_read(addr), wd), m_cyc[31:0]};
            else                              m_cyc <= m_cyc + 64'd1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!done) begin
            chk("cmp_rdata",   64'(rd32), 64'(m_ill(addr, op) ? 32'h0 : m_read(addr)));
            chk("cmp_illegal", 64'(ill32), 64'(m_ill(addr, op)));
            chk("cmp_mtvec",   64'(mtvec32), 64'(m_mtvec));
            chk("cmp_mepc",    64'(mepc32), 64'(m_mepc));
            chk("cmp_mie",     64'(mie32), 64'(m_mie));
        end
    end

    task automatic step_tm(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d,
                           input logic t, input logic [31:0] p, input logic [31:0] c,
                           input logic m);
        @(posedge clk);
        #1;
        addr = a; op = o; wd = d; trap = t; pc = p; cause = c; mret = m;
        @(negedge clk);
    endtask

    task automatic step(input logic [11:0] a, input logic [1:0] o, input logic [31:0] d);
        step_tm(a, o, d, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0; addr = 12'hB00; op = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; addr = 12'h0; op = 2'b00; wd = 32'h0; trap = 1'b0;
        pc = 32'h0; cause = 32'h0; mret = 1'b0; retire = 1'b0; done = 1'b0;

        step(12'h300, 2'b00, 32'h0);
        step(12'h300, 2'b00, 32'h0);
        chk("por_mstatus", 64'(rd32), 64'h1800);
        release_reset();
        chk("por_mcycle0", 64'(rd32), 64'h0);
        step(12'hB00, 2'b00, 32'h0);
        chk("por_mcycle1", 64'(rd32), 64'h1);
        chk("por_mtvec64", mtvec64, 64'h1000);

        step(12'h300, 2'b10, 32'h8);
        step(12'h340, 2'b01, 32'h1234);
        step(12'h300, 2'b00, 32'h0);
        chk("pre_rst_mie", 64'(mie32), 64'h1);
        #1 rst = 1'b1;
        #1;
        chk("arst_mstatus",   64'(rd32), 64'h1800);
        chk("arst_mtvec",     64'(mtvec32), 64'h1000);
        chk("arst_mie",       64'(mie32), 64'h0);
        chk("arst_mstatus64", rd64, 64'h1800);
        release_reset();
        chk("rst_mcycle0", 64'(rd32), 64'h0);
        step(12'hB00, 2'b00, 32'h0);
        chk("rst_mcycle1", 64'(rd32), 64'h1);

        step(12'h340, 2'b01, 32'hA5A5_0F0F);
        chk("scr_rw_old", 64'(rd32), 64'h0);
        step(12'h340, 2'b10, 32'h0000_00F0);
        chk("scr_rs_old", 64'(rd32), 64'hA5A5_0F0F);
        step(12'h340, 2'b11, 32'h0000_000F);
        chk("scr_rc_old", 64'(rd32), 64'hA5A5_0FFF);
        step(12'h340, 2'b00, 32'h0);
        chk("scr_final", 64'(rd32), 64'hA5A5_0FF0);

        step(12'h300, 2'b10, 32'h8);
        step_tm(12'h000, 2'b00, 32'h0, 1'b1, 32'h8000_0102, 32'd11, 1'b0);
        step(12'h342, 2'b00, 32'h0);
        chk("trap_mcause", 64'(rd32), 64'd11);
        chk("trap_mepc",   64'(mepc32), 64'h8000_0100);
        chk("trap_mie",    64'(mie32), 64'h0);
        step(12'h300, 2'b00, 32'h0);
        chk("trap_mstatus", 64'(rd32), 64'h1880);
        step_tm(12'h000, 2'b00, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(12'h300, 2'b00, 32'h0);
        chk("mret_mstatus", 64'(rd32), 64'h1888);
        chk("mret_mie",     64'(mie32), 64'h1);

        step(12'hB00, 2'b01, 32'hFFFF_FFFF);
        step(12'hB80, 2'b01, 32'h0);
        step(12'hB00, 2'b00, 32'h0);
        chk("cyc_lo_held", 64'(rd32), 64'hFFFF_FFFF);
        step(12'hB80, 2'b00, 32'h0);
        chk("cyc_carry_hi", 64'(rd32), 64'h1);
        step(12'hB00, 2'b00, 32'h0);
        chk("cyc_wrapped_lo", 64'(rd32), 64'h1);
        step(12'hB00, 2'b01, 32'h5);
        step(12'hB00, 2'b00, 32'h0);
        chk("cyc_wr5", 64'(rd32), 64'h5);
        step(12'hB00, 2'b00, 32'h0);
        chk("cyc_wr5_inc", 64'(rd32), 64'h6);

        step(12'hF11, 2'b01, 32'hDEAD_BEEF);
        chk("ill_f11", 64'(ill32), 64'h1);
        chk("ill_f11_rd", 64'(rd32), 64'h0);
        step(12'h7C0, 2'b01, 32'h1234);
        chk("ill_7c0", 64'(ill32), 64'h1);
        chk("ill_7c0_rd", 64'(rd32), 64'h0);
        step(12'hF12, 2'b01, 32'h0);
        chk("ill_f12", 64'(ill32), 64'h1);
        step(12'hF12, 2'b00, 32'h0);
        chk("marchid_rd", 64'(rd32), 64'h2A);
        step(12'hB80, 2'b10, 32'h2);
        chk("ill64_b80", 64'(ill64), 64'h1);
        chk("ill64_b80_rd", rd64, 64'h0);
        chk("legal32_b80", 64'(ill32), 64'h0);
        step(12'hB80, 2'b00, 32'h0);
        chk("cyc_hi_rs", 64'(rd32), 64'h3);
        step(12'h340, 2'b00, 32'h0);
        chk("scr64_kept", rd64, 64'hA5A5_0FF0);

        step(12'h300, 2'b11, 32'h8);
        step_tm(12'h305, 2'b01, 32'h100, 1'b1, 32'h0000_2006, 32'd7, 1'b1);
        chk("combo_legal", 64'(ill32), 64'h0);
        step(12'h300, 2'b00, 32'h0);
        chk("combo_mstatus", 64'(rd32), 64'h1800);
        chk("combo_mtvec",   64'(mtvec32), 64'h1000);
        chk("combo_mepc",    64'(mepc32), 64'h2004);
        step(12'h342, 2'b00, 32'h0);
        chk("combo_mcause", 64'(rd32), 64'd7);

        step_tm(12'hB00, 2'b01, 32'h0, 1'b1, 32'h0, 32'h0, 1'b0);
        step(12'hB00, 2'b00, 32'h0);
        step(12'h000, 2'b00, 32'h0);

        @(posedge clk);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
